// File: rtl/fpga_cfg_pkg.sv
// Shared fixed-point configuration for the FPGA datapath blocks.
// Latency: n/a (constants only).
// Backpressure: n/a.
package fpga_cfg_pkg;
    parameter int FP_WIDTH = 16;
endpackage

// File: rtl/icdf_lane_scheduler_if.sv
// Bundle of all handshake/bus signals around icdf_lane_scheduler.
// Latency: n/a (wiring only).
// Backpressure: n/a; master = scheduler side, slave = lanes/pipeline/consumers side.
// Ports: batch control (start, n_samples, busy, done, tag_err), lane request
// side (lane_*), shared pipeline side (icdf_*, res_*), per-lane result side (out_*).
interface icdf_lane_scheduler_if #(
    parameter int WIDTH   = fpga_cfg_pkg::FP_WIDTH,
    parameter int N_LANES = 4,
    parameter int CNT_W   = 16
);
    logic                       start;
    logic [CNT_W-1:0]           n_samples;
    logic                       busy;
    logic                       done;
    logic                       tag_err;

    logic [N_LANES-1:0]         lane_valid;
    logic [N_LANES*WIDTH-1:0]   lane_u;
    logic [N_LANES-1:0]         lane_ready;

    logic                       icdf_valid;
    logic [WIDTH-1:0]           icdf_u;
    logic                       icdf_ready;

    logic                       res_valid;
    logic [WIDTH-1:0]           res_z;
    logic                       res_ready;

    logic [N_LANES-1:0]         out_valid;
    logic [WIDTH-1:0]           out_z;
    logic [N_LANES-1:0]         out_ready;

    modport master (
        input  start, n_samples, lane_valid, lane_u, icdf_ready, res_valid, res_z, out_ready,
        output busy, done, tag_err, lane_ready, icdf_valid, icdf_u, res_ready, out_valid, out_z
    );

    modport slave (
        output start, n_samples, lane_valid, lane_u, icdf_ready, res_valid, res_z, out_ready,
        input  busy, done, tag_err, lane_ready, icdf_valid, icdf_u, res_ready, out_valid, out_z
    );
endinterface

// File: rtl/icdf_lane_scheduler.sv
// Shares one inverse-CDF pipeline between N_LANES Sobol lanes for a batch of n_samples each.
// Latency: grant -> icdf_valid next cycle; result -> out_valid combinational pass-through.
// Backpressure: icdf_ready holds the issue register; out_ready of the head lane stalls res_ready.
// Ports: clk, rst_n (async, active-low) plus the master side of icdf_lane_scheduler_if:
// batch control, round-robin lane grants, issue register to the pipeline, tag-routed results.
module icdf_lane_scheduler #(
    parameter int WIDTH        = fpga_cfg_pkg::FP_WIDTH,
    parameter int N_LANES      = 4,
    parameter int MAX_INFLIGHT = 16,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    icdf_lane_scheduler_if.master bus
);
    localparam int LW = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam int PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int OW = $clog2(MAX_INFLIGHT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   n_reg;
    logic [CNT_W-1:0]   count [N_LANES];
    logic [LW-1:0]      rr;
    logic               issue_vld;
    logic [WIDTH-1:0]   issue_u;
    logic [LW-1:0]      tag_mem [MAX_INFLIGHT];
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [OW-1:0]      occ;
    logic               tag_err_q;

    logic               fifo_empty, pop, push, can_load, found, all_done;
    logic [LW-1:0]      head, gnt_idx;
    logic [OW-1:0]      occ_after_pop;
    logic [N_LANES-1:0] eligible;

    assign fifo_empty    = (occ == '0);
    assign head          = tag_mem[rd_ptr];
    assign pop           = bus.res_valid && bus.res_ready;
    // pop only happens when non-empty, so this cannot underflow
    assign occ_after_pop = occ - OW'(pop);
    // Tag is pushed when the issue register loads, so occupancy covers the
    // register plus everything inside the shared pipeline.
    assign can_load      = (!issue_vld || bus.icdf_ready) && (state == S_RUN) &&
                           (occ_after_pop < OW'(MAX_INFLIGHT));
    assign push          = can_load && found;

    assign bus.res_ready  = !fifo_empty && bus.out_ready[head];
    assign bus.out_z      = bus.res_z;
    assign bus.icdf_valid = issue_vld;
    assign bus.icdf_u     = issue_u;
    assign bus.tag_err    = tag_err_q;

    always_comb begin
        eligible = '0;
        all_done = 1'b1;
        for (int i = 0; i < N_LANES; i++) begin
            eligible[i] = bus.lane_valid[i] && (count[i] < n_reg);
            if (count[i] != n_reg) all_done = 1'b0;
        end
    end

    // Round-robin: first eligible lane at or after rr.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < N_LANES; k++) begin
            if (!found && eligible[(int'(rr) + k) % N_LANES]) begin
                found   = 1'b1;
                gnt_idx = LW'((int'(rr) + k) % N_LANES);
            end
        end
    end

    always_comb begin
        bus.lane_ready = '0;
        if (push) bus.lane_ready[gnt_idx] = 1'b1;
        bus.out_valid = '0;
        if (bus.res_valid && !fifo_empty) bus.out_valid[head] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        unique case (state)
            S_IDLE:  if (bus.start) state_nxt = S_RUN;
            S_RUN: begin
                bus.busy = 1'b1;
                if (all_done && !issue_vld) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                bus.busy = 1'b1;
                if (fifo_empty) state_nxt = S_DONE;
            end
            S_DONE: begin
                bus.done  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_reg     <= '0;
            rr        <= '0;
            issue_vld <= 1'b0;
            issue_u   <= '0;
            tag_err_q <= 1'b0;
            for (int i = 0; i < N_LANES; i++) count[i] <= '0;
        end else begin
            if (state == S_IDLE && bus.start) begin
                n_reg <= bus.n_samples;
                for (int i = 0; i < N_LANES; i++) count[i] <= '0;
            end else if (push) begin
                count[gnt_idx] <= count[gnt_idx] + CNT_W'(1);
            end
            if (push) begin
                issue_vld <= 1'b1;
                issue_u   <= bus.lane_u[int'(gnt_idx)*WIDTH +: WIDTH];
                rr        <= LW'((int'(gnt_idx) + 1) % N_LANES);
            end else if (bus.icdf_ready) begin
                issue_vld <= 1'b0;
            end
            if (bus.res_valid && fifo_empty) tag_err_q <= 1'b1;
        end
    end

    // Tag FIFO pointers and occupancy; storage itself needs no reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PW'(MAX_INFLIGHT - 1)) ? '0 : wr_ptr + PW'(1);
            if (pop)  rd_ptr <= (rd_ptr == PW'(MAX_INFLIGHT - 1)) ? '0 : rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= gnt_idx;
    end
endmodule

// File: tb/tb_icdf_lane_scheduler.sv
// Testbench for icdf_lane_scheduler: batch vectors from a table plus hand-written corner sequences.
// Latency: models a 1-cycle shared pipeline behind icdf_valid/icdf_ready.
// Backpressure: randomised icdf_ready, out_ready and pipeline return rate per vector.
module tb_icdf_lane_scheduler;
    localparam int WIDTH        = fpga_cfg_pkg::FP_WIDTH;
    localparam int N_LANES      = 4;
    localparam int MAX_INFLIGHT = 16;
    localparam int CNT_W        = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    icdf_lane_scheduler_if #(.WIDTH(WIDTH), .N_LANES(N_LANES), .CNT_W(CNT_W)) bus ();

    icdf_lane_scheduler #(
        .WIDTH(WIDTH), .N_LANES(N_LANES), .MAX_INFLIGHT(MAX_INFLIGHT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        int lane;
        logic [WIDTH-1:0] z;
    } exp_t;

    typedef struct {
        int n;
        int rdy_pct;
        int ordy_pct;
        int ret_pct;
        int exp_lat;
    } vec_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] iss_q[$];
    logic [WIDTH-1:0] pipe_q[$];
    int               grant_log[$];

    int   errors = 0, checks = 0;
    int   rdy_pct = 100, ordy_pct = 100, ret_pct = 100;
    bit   ordy_fixed = 0, force_res = 0, start_req = 0, done_seen = 0;
    logic [3:0] ordy_force = 4'hF;
    logic [3:0] lane_mask = 4'hF;
    int   seq[N_LANES];
    int   rx_cnt[N_LANES];
    int   batch_grants = 0, done_cnt = 0;
    logic last_busy = 1'b0, prev_busy = 1'b0, last_res_ready = 1'b0;
    logic [3:0] last_out_valid = '0;

    function automatic logic [WIDTH-1:0] mk_u(input int lane, input int s);
        return WIDTH'(lane * 4096 + (s % 4096));
    endfunction

    function automatic logic [WIDTH-1:0] zf(input logic [WIDTH-1:0] u);
        return u ^ WIDTH'(16'hA5C3);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // One clock: drive at negedge, observe 1ns later, update the model for the coming edge.
    task automatic cycle();
        logic [3:0] lr, ov;
        int g, l;
        @(negedge clk);
        bus.start      = start_req;
        start_req      = 0;
        bus.icdf_ready = ($urandom_range(0, 99) < rdy_pct);
        for (int i = 0; i < N_LANES; i++) begin
            bus.out_ready[i] = ordy_fixed ? ordy_force[i] : ($urandom_range(0, 99) < ordy_pct);
            bus.lane_u[i*WIDTH +: WIDTH] = mk_u(i, seq[i]);
        end
        bus.lane_valid = lane_mask;
        if (force_res) begin
            bus.res_valid = 1'b1;
            bus.res_z     = WIDTH'(16'hDEAD);
        end else if (pipe_q.size() > 0 && $urandom_range(0, 99) < ret_pct) begin
            bus.res_valid = 1'b1;
            bus.res_z     = zf(pipe_q[0]);
        end else begin
            bus.res_valid = 1'b0;
            bus.res_z     = '0;
        end
        #1;
        lr             = bus.lane_ready;
        ov             = bus.out_valid;
        prev_busy      = last_busy;
        last_busy      = bus.busy;
        last_out_valid = ov;
        last_res_ready = bus.res_ready;

        // return path, against the model of the tag FIFO (exp_q)
        if (bus.res_valid) begin
            if (exp_q.size() == 0) begin
                check("empty_route", {ov, bus.res_ready}, 5'b0);
            end else begin
                l = exp_q[0].lane;
                check("route_valid", ov, 4'b0001 << l);
                check("route_ready", bus.res_ready, bus.out_ready[l]);
                if (bus.res_ready) begin
                    check("out_z", bus.out_z, exp_q[0].z);
                    void'(exp_q.pop_front());
                    rx_cnt[l]++;
                    if (pipe_q.size() > 0) void'(pipe_q.pop_front());
                end
            end
        end else begin
            check("idle_route", ov, 4'b0);
        end

        if (bus.icdf_valid && bus.icdf_ready) begin
            if (iss_q.size() == 0) begin
                check("spurious_issue", 1, 0);
            end else begin
                check("icdf_u", bus.icdf_u, iss_q[0]);
                void'(iss_q.pop_front());
                pipe_q.push_back(bus.icdf_u);
            end
        end

        if (lr != 4'b0) begin
            check("grant_onehot", $countones(lr), 1);
            g = 0;
            for (int i = N_LANES - 1; i >= 0; i--) if (lr[i]) g = i;
            exp_q.push_back('{lane: g, z: zf(mk_u(g, seq[g]))});
            iss_q.push_back(mk_u(g, seq[g]));
            seq[g]++;
            batch_grants++;
            grant_log.push_back(g);
        end

        if (bus.done) begin
            done_cnt++;
            done_seen = 1;
            check("busy_at_done", bus.busy, 1'b0);
        end
    endtask

    task automatic start_batch(input int n);
        bus.n_samples = CNT_W'(n);
        start_req     = 1;
        batch_grants  = 0;
        done_cnt      = 0;
        done_seen     = 0;
        grant_log.delete();
        for (int i = 0; i < N_LANES; i++) rx_cnt[i] = 0;
    endtask

    task automatic finish_batch(input int n, input int exp_lat, input int max_cyc);
        int k, bad;
        bit got;
        logic [63:0] rxp, rxe;
        got = 0;
        k   = 0;
        while (!got && k < max_cyc) begin
            cycle();
            if (done_seen) got = 1;
            else k++;
        end
        check("batch_done_in_time", got, 1'b1);
        if (exp_lat > 0) check("done_latency", k, exp_lat);
        check("busy_before_done", prev_busy, 1'b1);
        repeat (3) cycle();
        check("done_pulses", done_cnt, 1);
        check("grants", batch_grants, N_LANES * n);
        rxp = '0;
        rxe = '0;
        for (int i = 0; i < N_LANES; i++) begin
            rxp[i*16 +: 16] = 16'(rx_cnt[i]);
            rxe[i*16 +: 16] = 16'(n);
        end
        check("rx_counts", rxp, rxe);
        check("scoreboard_empty", exp_q.size(), 0);
        bad = 0;
        foreach (grant_log[j]) if (grant_log[j] != j % N_LANES) bad++;
        check("rr_order", bad, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        pipe_q.delete();
        exp_q.delete();
        iss_q.delete();
        bus.res_valid = 1'b0;
        bus.res_z     = '0;
        bus.start     = 1'b0;
        rst_n         = 1'b0;
        #1;
        check("reset_outputs",
              {bus.busy, bus.done, bus.tag_err, bus.lane_ready, bus.icdf_valid,
               bus.icdf_u, bus.res_ready, bus.out_valid}, 64'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        logic [WIDTH-1:0] u0;
        int bp_bad, k;

        vecs[0] = '{n: 3, rdy_pct: 100, ordy_pct: 100, ret_pct: 100, exp_lat: 0};
        vecs[1] = '{n: 1, rdy_pct: 100, ordy_pct: 100, ret_pct: 100, exp_lat: 0};
        vecs[2] = '{n: 0, rdy_pct: 100, ordy_pct: 100, ret_pct: 100, exp_lat: 3};
        vecs[3] = '{n: 4, rdy_pct: 60,  ordy_pct: 70,  ret_pct: 50,  exp_lat: 0};
        vecs[4] = '{n: 6, rdy_pct: 80,  ordy_pct: 40,  ret_pct: 80,  exp_lat: 0};
        vecs[5] = '{n: 2, rdy_pct: 100, ordy_pct: 100, ret_pct: 30,  exp_lat: 0};

        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.n_samples  = '0;
        bus.lane_valid = '0;
        bus.lane_u     = '0;
        bus.icdf_ready = 1'b0;
        bus.res_valid  = 1'b0;
        bus.res_z      = '0;
        bus.out_ready  = '0;
        for (int i = 0; i < N_LANES; i++) begin
            seq[i]    = 0;
            rx_cnt[i] = 0;
        end
        do_reset();

        // table-driven batches
        for (int v = 0; v < 6; v++) begin
            rdy_pct  = vecs[v].rdy_pct;
            ordy_pct = vecs[v].ordy_pct;
            ret_pct  = vecs[v].ret_pct;
            start_batch(vecs[v].n);
            finish_batch(vecs[v].n, vecs[v].exp_lat, 2000);
        end
        rdy_pct  = 100;
        ordy_pct = 100;

        // icdf_ready held low: issue register frozen, no grants
        start_batch(10);
        rdy_pct = 0;
        ret_pct = 0;
        cycle();
        cycle();
        cycle();
        u0 = bus.icdf_u;
        check("bp_valid", bus.icdf_valid, 1'b1);
        check("bp_u", u0, iss_q[0]);
        bp_bad = 0;
        repeat (5) begin
            cycle();
            if (bus.icdf_u !== u0 || bus.lane_ready != 4'b0 || bus.icdf_valid !== 1'b1) bp_bad++;
        end
        check("bp_stable", bp_bad, 0);
        check("bp_grants", batch_grants, 1);
        rdy_pct = 100;
        ret_pct = 100;
        finish_batch(10, 0, 2000);

        // pipeline never returns: FIFO fills at MAX_INFLIGHT, one return frees one slot
        start_batch(10);
        ret_pct = 0;
        repeat (30) cycle();
        check("full_grants", batch_grants, MAX_INFLIGHT);
        ret_pct = 100;
        cycle();
        ret_pct = 0;
        repeat (10) cycle();
        check("full_one_more", batch_grants, MAX_INFLIGHT + 1);
        ret_pct = 100;
        finish_batch(10, 0, 2000);

        // head tag 2 with its consumer stalled
        do_reset();
        start_batch(1);
        ret_pct = 0;
        repeat (8) cycle();
        check("stall_setup", batch_grants, 4);
        ret_pct = 100;
        cycle();
        cycle();
        ret_pct = 0;
        check("stall_popped", rx_cnt[0] + rx_cnt[1], 2);
        ordy_fixed = 1;
        ordy_force = 4'b1011;
        ret_pct    = 100;
        repeat (3) begin
            cycle();
            check("stall_res_ready", last_res_ready, 1'b0);
            check("stall_out_valid", last_out_valid, 4'b0100);
        end
        ordy_force = 4'b1111;
        cycle();
        check("stall_release", last_res_ready, 1'b1);
        check("stall_rx2", rx_cnt[2], 1);
        ordy_fixed = 0;
        finish_batch(1, 0, 500);

        // reset with 5 samples in flight, then a clean batch
        start_batch(10);
        ret_pct = 0;
        k = 0;
        while (batch_grants < 5 && k < 50) begin
            cycle();
            k++;
        end
        check("mid_inflight", batch_grants, 5);
        do_reset();
        ret_pct = 100;
        start_batch(2);
        finish_batch(2, 0, 500);

        // result with empty tag FIFO sets a sticky error
        force_res = 1;
        cycle();
        force_res = 0;
        cycle();
        check("tag_err_set", bus.tag_err, 1'b1);
        repeat (4) cycle();
        check("tag_err_sticky", bus.tag_err, 1'b1);
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
